alu_serial_receiver: RTL and testbench
======================================

Name: alu_serial_receiver

Overview:
- Deserializes the ALU serial input line `sin` into complete operation frames: operands A and B, opcode, CRC-4.
- Checks frame structure, CRC and opcode, then presents one result record per command packet to the ALU core over a valid/ready handshake.
- Sits between the DUT pin `sin` and the ALU datapath.
- Is the receiving end of the packet stream the test bench drives.

Parameters:
- DATA_PACKETS, 8, number of data packets per complete frame (4 for B, then 4 for A).
- OP_W, 3, opcode width.
- CRC_W, 4, CRC width.

Ports:
- clk  input  1  system clock; one serial bit per rising edge.
- rst  input  1  synchronous, active-high reset.
- sin  input  1  serial line; idles high.
- out_valid  output  1  a decoded record is available.
- out_ready  input  1  consumer accepts the record when high together with out_valid.
- out_a  output  32  operand A.
- out_b  output  32  operand B.
- out_op  output  3  opcode.
- err_data  output  1  frame had the wrong number of data packets.
- err_crc  output  1  CRC mismatch.
- err_op  output  1  opcode not in {000, 001, 100, 101}.
- overflow  output  1  sticky; a record was dropped because the output register was still full.

Behaviour:
- Packet format: 11 bits on `sin`, one bit per clk.
  - Start bit 0.
  - Type bit: 0 = data, 1 = command.
  - 8 payload bits, MSB first.
  - Stop bit 1.
- Command payload = {1'b0, OP[2:0], CRC[3:0]}.
- Serial FSM states: IDLE, TYPE, PAYLOAD (bit counter 0..7), STOP.
  - IDLE → TYPE when sin == 0.
  - TYPE stores the type bit → PAYLOAD.
  - PAYLOAD shifts 8 bits → STOP.
  - STOP with sin == 1: packet accepted → IDLE.
  - STOP with sin == 0: packet discarded, treated as a new start bit → TYPE.
- Frame assembly:
  - Each accepted data packet shifts its byte into a 64-bit register {B, A}; the first byte received is B[31:24], the last is A[7:0].
  - data_cnt increments and saturates at DATA_PACKETS+1.
- On an accepted command packet, the record is formed:
  - err_data = (data_cnt != DATA_PACKETS).
  - When err_data = 1: err_crc = 0 and err_op = 0. A/B/op fields are don't-care, but the bench sees them as 0.
  - Otherwise err_crc = (CRC != crc4({B, A, 1'b1, OP})). crc4 uses polynomial x^4+x+1, init 0, over the 68 bits MSB first.
  - err_op is evaluated only when err_crc = 0 (priority: data > crc > op).
  - data_cnt and the shift register clear in the same cycle.
- Output register:
  - Loaded in the cycle after the STOP bit of the command packet; out_valid rises that cycle (latency 1 clk after the stop bit).
  - Holds stable until out_valid & out_ready; clears the cycle after acceptance.
  - If a new record completes while out_valid is high and out_ready is low: the new record is dropped, the held record is unchanged, overflow is set.
  - If out_ready is high in that same cycle: the old record is consumed and the new one is loaded (no drop).
- Reset (any cycle, including mid-packet):
  - FSM → IDLE.
  - data_cnt = 0, shift register = 0.
  - out_valid = 0, out_a = 0, out_b = 0, out_op = 0, all err_* = 0, overflow = 0.
  - A partially received packet is lost; after rst deasserts, the receiver waits for sin == 0.
- A data packet after 8 data packets keeps shifting, so the oldest byte is lost; the resulting frame reports err_data.
- A low sin held continuously is parsed as a data packet of zeros; its stop check then fails and the packet is discarded.

Test Plan:
1. Send B = 0x00000002 and A = 0x00000003 (8 data packets), then command op = 100 with the correct CRC → out_valid 1 clk after the stop bit; out_a = 3, out_b = 2, out_op = 100, all err = 0.
2. Same frame with the CRC XOR 0x1 → err_crc = 1, err_data = 0, err_op = 0.
3. 6 data packets, then a command → err_data = 1, err_crc = 0, fields = 0. The next full frame with A = B = 0xFFFFFFFF, op = 000 decodes cleanly.
4. Valid frame with op = 111 and the correct CRC → err_op = 1. Separately, a frame with both a bad CRC and op = 111 → only err_crc = 1.
5. Two valid frames back to back with out_ready held 0 → the first record held unchanged, overflow = 1. With out_ready = 1 in the second frame's completion cycle, the second record is loaded and overflow stays 0.
6. Assert rst for 1 clk in the middle of the 4th data packet, then send a full valid frame → all outputs 0 during reset; the following frame decodes correctly with no err_data.

Source files
------------

// File: rtl/alu_serial_receiver.sv
`default_nettype none
//==============================================================================
// Module   : alu_serial_receiver
// Summary  : Deserializes the ALU serial line into A/B/opcode frames, checks
//            frame length, CRC-4 and opcode, and hands one record per command
//            packet to the ALU core over a valid/ready handshake.
// Revision : 1.0 - initial release
//==============================================================================
module alu_serial_receiver #(
    parameter int DATA_PACKETS = 8,
    parameter int OP_W         = 3,
    parameter int CRC_W        = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_a,
    output logic [31:0]     out_b,
    output logic [OP_W-1:0] out_op,
    output logic            err_data,
    output logic            err_crc,
    output logic            err_op,
    output logic            overflow
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_type    = 2'd1;
    localparam logic [1:0] c_st_payload = 2'd2;
    localparam logic [1:0] c_st_stop    = 2'd3;

    localparam int c_cnt_w = $clog2(DATA_PACKETS + 2);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DATA_PACKETS);
    localparam logic [c_cnt_w-1:0] c_cnt_sat  = c_cnt_w'(DATA_PACKETS + 1);
    localparam int c_msg_w = 65 + OP_W;
    localparam logic [CRC_W-1:0] c_crc_poly = CRC_W'(3);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [2:0]         r_bit_cnt;
    logic               r_type;
    logic [7:0]         r_payload;
    logic [63:0]        r_shift;
    logic [c_cnt_w-1:0] r_data_cnt;

    logic               r_out_valid;
    logic [31:0]        r_out_a;
    logic [31:0]        r_out_b;
    logic [OP_W-1:0]    r_out_op;
    logic               r_err_data;
    logic               r_err_crc;
    logic               r_err_op;
    logic               r_overflow;

    logic               w_pkt_done;
    logic               w_data_done;
    logic               w_cmd_done;
    logic [OP_W-1:0]    w_rx_op;
    logic [CRC_W-1:0]   w_rx_crc;
    logic               w_op_legal;
    logic               w_err_data;
    logic               w_err_crc;
    logic               w_err_op;

    // Serial CRC, polynomial x^4+x+1, zero init, message consumed MSB first.
    function automatic logic [CRC_W-1:0] crc4(input logic [c_msg_w-1:0] msg);
        logic [CRC_W-1:0] crc;
        logic             fb;
        crc = '0;
        for (int i = c_msg_w - 1; i >= 0; i--) begin
            fb  = crc[CRC_W-1] ^ msg[i];
            crc = {crc[CRC_W-2:0], 1'b0} ^ (fb ? c_crc_poly : '0);
        end
        return crc;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A low stop bit discards the packet and is reused as the next start bit.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:    if (!sin) w_state_next = c_st_type;
            c_st_type:    w_state_next = c_st_payload;
            c_st_payload: if (r_bit_cnt == 3'd7) w_state_next = c_st_stop;
            c_st_stop:    w_state_next = sin ? c_st_idle : c_st_type;
            default:      w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= 3'd0;
            r_type    <= 1'b0;
            r_payload <= 8'd0;
        end else if (r_state == c_st_type) begin
            r_type    <= sin;
            r_bit_cnt <= 3'd0;
        end else if (r_state == c_st_payload) begin
            r_payload <= {r_payload[6:0], sin};
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    assign w_pkt_done  = (r_state == c_st_stop) && sin;
    assign w_data_done = w_pkt_done && !r_type;
    assign w_cmd_done  = w_pkt_done && r_type;

    assign w_rx_op  = r_payload[CRC_W +: OP_W];
    assign w_rx_crc = r_payload[CRC_W-1:0];

    assign w_op_legal = (w_rx_op == OP_W'(0)) || (w_rx_op == OP_W'(1)) ||
                        (w_rx_op == OP_W'(4)) || (w_rx_op == OP_W'(5));

    // Error priority: frame length, then CRC, then opcode.
    assign w_err_data = (r_data_cnt != c_cnt_full);
    assign w_err_crc  = !w_err_data && (w_rx_crc != crc4({r_shift, 1'b1, w_rx_op}));
    assign w_err_op   = !w_err_data && !w_err_crc && !w_op_legal;

    always_ff @(posedge clk) begin
        if (rst || w_cmd_done) begin
            r_shift    <= 64'd0;
            r_data_cnt <= '0;
        end else if (w_data_done) begin
            r_shift <= {r_shift[55:0], r_payload};
            if (r_data_cnt != c_cnt_sat) begin
                r_data_cnt <= r_data_cnt + 1'b1;
            end
        end
    end

    // A completing record is dropped only if the held one is not taken this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_a     <= 32'd0;
            r_out_b     <= 32'd0;
            r_out_op    <= '0;
            r_err_data  <= 1'b0;
            r_err_crc   <= 1'b0;
            r_err_op    <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_cmd_done && r_out_valid && !out_ready) begin
            r_overflow <= 1'b1;
        end else if (w_cmd_done) begin
            r_out_valid <= 1'b1;
            r_out_a     <= w_err_data ? 32'd0 : r_shift[31:0];
            r_out_b     <= w_err_data ? 32'd0 : r_shift[63:32];
            r_out_op    <= w_err_data ? '0 : w_rx_op;
            r_err_data  <= w_err_data;
            r_err_crc   <= w_err_crc;
            r_err_op    <= w_err_op;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_out_a     <= 32'd0;
            r_out_b     <= 32'd0;
            r_out_op    <= '0;
            r_err_data  <= 1'b0;
            r_err_crc   <= 1'b0;
            r_err_op    <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign out_op    = r_out_op;
    assign err_data  = r_err_data;
    assign err_crc   = r_err_crc;
    assign err_op    = r_err_op;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_receiver.sv
`default_nettype none
//==============================================================================
// Module   : tb_alu_serial_receiver
// Summary  : Scoreboard bench for alu_serial_receiver.
// Revision : 1.0 - initial release
//==============================================================================
module tb_alu_serial_receiver;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        ed;
        logic        ec;
        logic        eo;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        sin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [2:0]  out_op;
    logic        err_data;
    logic        err_crc;
    logic        err_op;
    logic        overflow;

    rec_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic pre_valid;

    alu_serial_receiver #(.DATA_PACKETS(8), .OP_W(3), .CRC_W(4)) dut (
        .clk(clk), .rst(rst), .sin(sin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_op(out_op),
        .err_data(err_data), .err_crc(err_crc), .err_op(err_op),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // CRC as polynomial long division of the message times x^4 by 10011.
    function automatic logic [3:0] model_crc(input logic [31:0] b, input logic [31:0] a,
                                             input logic [2:0] op);
        logic [71:0] m;
        m = {b, a, 1'b1, op, 4'b0000};
        for (int i = 71; i >= 4; i--) begin
            if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
        end
        return m[3:0];
    endfunction

    function automatic rec_t model_rec(input logic [31:0] b, input logic [31:0] a,
                                       input logic [2:0] op, input logic [3:0] crc,
                                       input int ndata);
        rec_t r;
        r = '0;
        if (ndata != 8) begin
            r.ed = 1'b1;
        end else begin
            r.a  = a;
            r.b  = b;
            r.op = op;
            r.ec = (crc != model_crc(b, a, op));
            r.eo = !r.ec && !(op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd5);
        end
        return r;
    endfunction

    function automatic rec_t get_rec();
        rec_t r;
        r.a  = out_a;
        r.b  = out_b;
        r.op = out_op;
        r.ed = err_data;
        r.ec = err_crc;
        r.eo = err_op;
        return r;
    endfunction

    task automatic send_bit(input logic b);
        sin = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic t, input logic [7:0] pay, input logic ready_at_stop);
        send_bit(1'b0);
        send_bit(t);
        for (int i = 7; i >= 0; i--) send_bit(pay[i]);
        pre_valid = out_valid;
        if (ready_at_stop) out_ready = 1'b1;
        send_bit(1'b1);
    endtask

    task automatic send_frame(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                              input logic [3:0] crc_xor, input int ndata,
                              input logic ready_at_stop, input logic push);
        logic [63:0] d;
        logic [3:0]  crc;
        d = {b, a};
        for (int i = 0; i < ndata; i++) begin
            if (i < 8) send_pkt(1'b0, d[63 - 8*i -: 8], 1'b0);
            else       send_pkt(1'b0, 8'h5A, 1'b0);
        end
        crc = model_crc(b, a, op) ^ crc_xor;
        if (push) q.push_back(model_rec(b, a, op, crc, ndata));
        send_pkt(1'b1, {1'b0, op, crc}, ready_at_stop);
    endtask

    task automatic test_reset();
        rst = 1'b1; sin = 1'b1; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (get_rec() !== rec_t'(0)) begin n_fail++; $display("FAIL reset_fields: got %h expected 0", get_rec()); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_frame(32'h2, 32'h3, 3'b100, 4'h0, 8, 1'b0, 1'b1);
        n_checks++;
        if (pre_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", pre_valid); end
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got %b expected 1", out_valid); end
        n_checks++;
        if (get_rec() !== q[0]) begin n_fail++; $display("FAIL basic_record: got %h expected %h", get_rec(), q[0]); end
        void'(q.pop_front());
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, get_rec()} !== 71'd0) begin
            n_fail++; $display("FAIL basic_clear: got %h expected 0", {out_valid, get_rec()});
        end
    endtask

    task automatic test_crc_error();
        send_frame(32'h2, 32'h3, 3'b100, 4'h1, 8, 1'b0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || get_rec() !== q[0]) begin
            n_fail++; $display("FAIL crc_error: got %b/%h expected 1/%h", out_valid, get_rec(), q[0]);
        end
        void'(q.pop_front());
    endtask

    task automatic test_data_count();
        send_frame(32'h11223344, 32'h55667788, 3'b001, 4'h0, 6, 1'b0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || get_rec() !== q[0]) begin
            n_fail++; $display("FAIL short_frame: got %b/%h expected 1/%h", out_valid, get_rec(), q[0]);
        end
        void'(q.pop_front());
        send_frame(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000, 4'h0, 8, 1'b0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || get_rec() !== q[0]) begin
            n_fail++; $display("FAIL all_ones_frame: got %b/%h expected 1/%h", out_valid, get_rec(), q[0]);
        end
        void'(q.pop_front());
        send_frame(32'hCAFEF00D, 32'h12345678, 3'b101, 4'h0, 9, 1'b0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || get_rec() !== q[0]) begin
            n_fail++; $display("FAIL long_frame: got %b/%h expected 1/%h", out_valid, get_rec(), q[0]);
        end
        void'(q.pop_front());
    endtask

    task automatic test_bad_op();
        send_frame(32'hA5A5A5A5, 32'h0F0F0F0F, 3'b111, 4'h0, 8, 1'b0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || get_rec() !== q[0]) begin
            n_fail++; $display("FAIL bad_op: got %b/%h expected 1/%h", out_valid, get_rec(), q[0]);
        end
        void'(q.pop_front());
        send_frame(32'hA5A5A5A5, 32'h0F0F0F0F, 3'b111, 4'h6, 8, 1'b0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || get_rec() !== q[0]) begin
            n_fail++; $display("FAIL bad_op_and_crc: got %b/%h expected 1/%h", out_valid, get_rec(), q[0]);
        end
        void'(q.pop_front());
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_frame(32'h00000010, 32'h00000020, 3'b001, 4'h0, 8, 1'b0, 1'b1);
        send_frame(32'h00000030, 32'h00000040, 3'b101, 4'h0, 8, 1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || get_rec() !== q[0]) begin
            n_fail++; $display("FAIL held_record: got %b/%h expected 1/%h", out_valid, get_rec(), q[0]);
        end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %b expected 1", overflow); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        void'(q.pop_front());
        n_checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL drain_sticky: got valid %b ovf %b expected 0 1", out_valid, overflow);
        end

        rst = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        send_frame(32'h00000050, 32'h00000060, 3'b000, 4'h0, 8, 1'b0, 1'b1);
        send_frame(32'h00000070, 32'h00000080, 3'b100, 4'h0, 8, 1'b1, 1'b1);
        void'(q.pop_front());
        n_checks++;
        if (out_valid !== 1'b1 || get_rec() !== q[0]) begin
            n_fail++; $display("FAIL replace_record: got %b/%h expected 1/%h", out_valid, get_rec(), q[0]);
        end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_clear: got %b expected 0", overflow); end
        void'(q.pop_front());
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_frame(32'h00000001, 32'h00000001, 3'b000, 4'h0, 8, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) send_pkt(1'b0, 8'h9C, 1'b0);
        send_bit(1'b0); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        rst = 1'b1; sin = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, overflow, get_rec()} !== 72'd0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %h expected 0", {out_valid, overflow, get_rec()});
        end
        rst = 1'b0;
        q.delete();
        out_ready = 1'b1;
        send_frame(32'hDEADBEEF, 32'h01020304, 3'b101, 4'h0, 8, 1'b0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || get_rec() !== q[0]) begin
            n_fail++; $display("FAIL after_reset_frame: got %b/%h expected 1/%h", out_valid, get_rec(), q[0]);
        end
        void'(q.pop_front());
    endtask

    initial begin
        test_reset();
        test_basic();
        test_crc_error();
        test_data_count();
        test_bad_op();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
